// File: rtl/fft_pkg.sv
// Shared types and the index permutation used by the streaming FFT reorder buffer.
package fft_pkg;

  typedef enum logic [2:0] {
    MODE_BITREV = 3'd0,
    MODE_IDENT  = 3'd7
  } perm_mode_e;

  localparam int unsigned CPLX_DW = 16;

  typedef struct packed {
    logic [CPLX_DW-1:0] im;
    logic [CPLX_DW-1:0] re;
  } cplx_t;

  // Indices are carried at the maximum width (N <= 256); only the low log2n bits are meaningful.
  function automatic logic [7:0] perm_idx(input logic [7:0]  i,
                                          input int unsigned mode,
                                          input int unsigned log2n);
    logic [7:0] r;
    r = i;
    if (mode == 32'(MODE_BITREV)) begin
      r = '0;
      for (int unsigned b = 0; b < 8; b++) begin
        if (b < log2n) r[3'(b)] = i[3'(log2n - 1 - b)];
      end
    end else if (mode < log2n) begin
      r[0]        = i[3'(mode)];
      r[3'(mode)] = i[0];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_perm_bank.sv
// One N-entry sample bank: synchronous write port, combinational read port, no reset.
module fft_perm_bank #(
  parameter int unsigned N  = 32,
  parameter int unsigned W  = 32,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [N];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_perm_stream.sv
// Streaming ping-pong frame buffer emitting each N-point frame in a per-frame permuted order.
// Optional framing check enabled by FFT_PERM_STREAM_FRAME_CHECK_EN (adds s_last / frame_err).
module fft_perm_stream
  import fft_pkg::*;
#(
  parameter int unsigned N  = 32,
  parameter int unsigned DW = 16,
  parameter int unsigned MW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [2*DW-1:0] s_data,
  input  logic [MW-1:0]   s_mode,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [2*DW-1:0] m_data,
  output logic            m_last,
  output logic [MW-1:0]   m_mode
`ifdef FFT_PERM_STREAM_FRAME_CHECK_EN
  ,
  input  logic            s_last,
  output logic            frame_err
`endif
);

  localparam int unsigned LOG2N = $clog2(N);
  localparam int unsigned SW    = 2 * DW;

  logic [LOG2N-1:0] r_wcnt, r_rcnt;
  logic             r_wb, r_rb;
  logic [1:0]       r_full;
  logic [MW-1:0]    r_mode [2];
  logic             r_m_valid, r_m_last;
  logic [SW-1:0]    r_m_data;
  logic [MW-1:0]    r_m_mode;

  logic             w_acc, w_load, w_wlast, w_rlast;
  logic [1:0]       w_full_d;
  logic [MW-1:0]    w_rmode;
  logic [7:0]       w_perm_full;
  logic [LOG2N-1:0] w_raddr;
  logic [SW-1:0]    w_rdata [2];

  assign s_ready = rst_n & ~r_full[r_wb];
  assign w_acc   = s_valid & s_ready;
  assign w_wlast = (r_wcnt == LOG2N'(N - 1));
  assign w_rlast = (r_rcnt == LOG2N'(N - 1));
  assign w_load  = r_full[r_rb] & (~r_m_valid | m_ready);

  assign w_rmode     = r_mode[r_rb];
  assign w_perm_full = perm_idx(8'(r_rcnt), 32'(w_rmode), LOG2N);
  assign w_raddr     = w_perm_full[LOG2N-1:0];

  if (LOG2N < 8) begin : g_perm_hi
    logic unused_perm_hi;
    assign unused_perm_hi = ^w_perm_full[7:LOG2N];
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_perm_bank #(
      .N (N),
      .W (SW)
    ) u_bank (
      .i_clk   (clk),
      .i_we    (w_acc && (r_wb == 1'(b))),
      .i_waddr (r_wcnt),
      .i_wdata (s_data),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata[b])
    );
  end

  // Writer only targets an empty bank and reader only a full one, so set/clear never collide.
  always_comb begin
    w_full_d = r_full;
    if (w_acc && w_wlast) w_full_d[r_wb] = 1'b1;
    if (w_load && w_rlast) w_full_d[r_rb] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wcnt    <= '0;
      r_rcnt    <= '0;
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
      r_full    <= '0;
      r_mode[0] <= '0;
      r_mode[1] <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_m_mode  <= '0;
    end else begin
      r_full <= w_full_d;
      if (w_acc) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (r_wcnt == '0) r_mode[r_wb] <= s_mode;
        if (w_wlast) r_wb <= ~r_wb;
      end
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_rdata[r_rb];
        r_m_mode  <= w_rmode;
        r_m_last  <= w_rlast;
        r_rcnt    <= r_rcnt + 1'b1;
        if (w_rlast) r_rb <= ~r_rb;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_last  = r_m_last;
  assign m_mode  = r_m_mode;

`ifdef FFT_PERM_STREAM_FRAME_CHECK_EN
  logic r_frame_err;

  // s_last is advisory: it only flags disagreement with the counter-derived frame boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_err <= 1'b0;
    end else if (w_acc && (s_last != w_wlast)) begin
      r_frame_err <= 1'b1;
    end
  end

  assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_fft_perm_stream.sv
// Directed, table-checked bench for fft_perm_stream (N=32, DW=16).
module tb_fft_perm_stream;
  import fft_pkg::*;

  localparam int unsigned N  = 32;
  localparam int unsigned DW = 16;
  localparam int unsigned MW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   s_data = '0;
  logic [2:0]    s_mode = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [31:0]   m_data;
  logic          m_last;
  logic [2:0]    m_mode;
  logic          s_last = 1'b0;
`ifdef FFT_PERM_STREAM_FRAME_CHECK_EN
  logic          frame_err;
`endif

  fft_perm_stream #(
    .N  (N),
    .DW (DW),
    .MW (MW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_mode  (s_mode),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .m_mode  (m_mode)
`ifdef FFT_PERM_STREAM_FRAME_CHECK_EN
    ,
    .s_last    (s_last),
    .frame_err (frame_err)
`endif
  );

  typedef struct {
    int         frame;
    int         pos;
    logic [15:0] re;
    logic [2:0]  mode;
  } vec_t;

  vec_t       vecs[$];
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         nout = 0;
  cplx_t      frames[9][32];
  logic [2:0] fmode[9][32];
  logic       flast[9][32];
  int         out_cyc[288];
  int         acc_cyc[$];
  logic       held_prev = 1'b0;
  logic [35:0] held_val = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Record accepts and transfers; held outputs must not change.
  always @(negedge clk) begin
    if (s_valid && s_ready) acc_cyc.push_back(cyc);
    if (held_prev && m_valid) chk("hold_stable", 64'({m_data, m_last, m_mode}), 64'(held_val));
    if (m_valid && m_ready && nout < 288) begin
      frames[nout/32][nout%32] = m_data;
      fmode[nout/32][nout%32]  = m_mode;
      flast[nout/32][nout%32]  = m_last;
      out_cyc[nout] = cyc;
      nout++;
    end
    held_prev = rst_n && m_valid && !m_ready;
    held_val  = {m_data, m_last, m_mode};
  end

  task automatic accept_one(input int i, input logic [2:0] mode, input logic last);
    int guard;
    bit got;
    s_valid = 1'b1;
    s_data  = {16'(256 + i), 16'(i)};
    s_mode  = mode;
    s_last  = last;
    guard   = 0;
    got     = 1'b0;
    while (!got && guard < 2000) begin
      @(negedge clk);
      got = s_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!got) chk("accept_in_budget", 64'(got), 64'd1);
  endtask

  task automatic send(input int n, input logic [2:0] mode);
    for (int i = 0; i < n; i++) accept_one(i, mode, i == N - 1);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_out(input int target, input int budget);
    int c;
    c = 0;
    while (nout < target && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk($sformatf("outputs_reach_%0d", target), 64'(nout >= target), 64'd1);
  endtask

  task automatic reset_pulse(input int cycles);
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, failed=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    // {frame, position, expected real, expected mode}; imag is expected to be 0x100 + real
    vecs.push_back('{0, 0, 16'd0, 3'd0});   vecs.push_back('{0, 1, 16'd16, 3'd0});
    vecs.push_back('{0, 2, 16'd8, 3'd0});   vecs.push_back('{0, 3, 16'd24, 3'd0});
    vecs.push_back('{0, 4, 16'd4, 3'd0});   vecs.push_back('{0, 5, 16'd20, 3'd0});
    vecs.push_back('{0, 9, 16'd18, 3'd0});  vecs.push_back('{0, 17, 16'd17, 3'd0});
    vecs.push_back('{0, 30, 16'd15, 3'd0}); vecs.push_back('{0, 31, 16'd31, 3'd0});
    vecs.push_back('{1, 0, 16'd0, 3'd1});   vecs.push_back('{1, 1, 16'd2, 3'd1});
    vecs.push_back('{1, 2, 16'd1, 3'd1});   vecs.push_back('{1, 3, 16'd3, 3'd1});
    vecs.push_back('{1, 4, 16'd4, 3'd1});   vecs.push_back('{1, 5, 16'd6, 3'd1});
    vecs.push_back('{1, 6, 16'd5, 3'd1});   vecs.push_back('{1, 7, 16'd7, 3'd1});
    vecs.push_back('{1, 9, 16'd10, 3'd1});  vecs.push_back('{1, 31, 16'd31, 3'd1});
    vecs.push_back('{2, 0, 16'd0, 3'd2});   vecs.push_back('{2, 1, 16'd4, 3'd2});
    vecs.push_back('{2, 2, 16'd2, 3'd2});   vecs.push_back('{2, 3, 16'd6, 3'd2});
    vecs.push_back('{2, 4, 16'd1, 3'd2});   vecs.push_back('{2, 5, 16'd5, 3'd2});
    vecs.push_back('{2, 6, 16'd3, 3'd2});   vecs.push_back('{2, 7, 16'd7, 3'd2});
    vecs.push_back('{2, 8, 16'd8, 3'd2});   vecs.push_back('{2, 9, 16'd12, 3'd2});
    vecs.push_back('{2, 13, 16'd13, 3'd2});
    vecs.push_back('{3, 0, 16'd0, 3'd7});   vecs.push_back('{3, 1, 16'd1, 3'd7});
    vecs.push_back('{3, 15, 16'd15, 3'd7}); vecs.push_back('{3, 31, 16'd31, 3'd7});
    vecs.push_back('{4, 1, 16'd1, 3'd5});   vecs.push_back('{4, 16, 16'd16, 3'd5});
    vecs.push_back('{4, 30, 16'd30, 3'd5});
    vecs.push_back('{5, 1, 16'd8, 3'd3});   vecs.push_back('{5, 8, 16'd1, 3'd3});
    vecs.push_back('{5, 3, 16'd10, 3'd3});  vecs.push_back('{5, 31, 16'd31, 3'd3});
    vecs.push_back('{6, 1, 16'd16, 3'd4});  vecs.push_back('{6, 16, 16'd1, 3'd4});
    vecs.push_back('{6, 17, 16'd17, 3'd4}); vecs.push_back('{6, 2, 16'd2, 3'd4});
    vecs.push_back('{7, 0, 16'd0, 3'd0});   vecs.push_back('{7, 1, 16'd16, 3'd0});
    vecs.push_back('{7, 3, 16'd24, 3'd0});  vecs.push_back('{7, 6, 16'd12, 3'd0});
    vecs.push_back('{7, 31, 16'd31, 3'd0});

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_mode", 64'(m_mode), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("s_ready_after_reset", 64'(s_ready), 64'd1);

    // Frame 0: bit-reverse, latency
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    acc_cyc.delete();
    send(32, 3'd0);
    wait_out(32, 200);
    chk("first_out_latency", 64'(acc_cyc.size() >= 32 ? out_cyc[0] - acc_cyc[31] : -1), 64'd2);

    // Frames 1,2 back to back: butterfly pairings, bubble bound
    send(32, 3'd1);
    send(32, 3'd2);
    wait_out(96, 300);
    chk("interframe_gap_le_3", 64'(out_cyc[64] - out_cyc[63] <= 3), 64'd1);

    // Frame 3: identity with m_ready toggling
    fork
      send(32, MODE_IDENT);
      begin
        int c;
        c = 0;
        while (nout < 128 && c < 400) begin
          @(posedge clk);
          #1;
          m_ready = ~m_ready;
          c++;
        end
      end
    join
    m_ready = 1'b1;
    chk("toggle_outputs", 64'(nout), 64'd128);

    // Frames 4..6: backpressure with both banks full
    m_ready = 1'b0;
    acc_cyc.delete();
    fork
      begin
        send(32, 3'd5);
        send(32, 3'd3);
        send(32, 3'd4);
      end
      begin
        int c;
        c = 0;
        while (acc_cyc.size() < 64 && c < 300) begin
          @(posedge clk);
          #1;
          c++;
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_accepts_stalled", 64'(acc_cyc.size()), 64'd64);
        chk("bp_s_ready_low", 64'(s_ready), 64'd0);
        chk("bp_no_outputs", 64'(nout), 64'd128);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_out(224, 600);
      end
    join
    chk("third_frame_after_free",
        64'(acc_cyc.size() >= 65 ? acc_cyc[64] >= out_cyc[159] : 1'b0), 64'd1);

    // Mid-frame reset, then a clean bit-reverse frame
    m_ready = 1'b0;
    send(32, 3'd0);
    send(10, 3'd0);
    m_ready = 1'b1;
    for (int c = 0; c < 100 && nout < 229; c++) begin
      @(posedge clk);
      #1;
    end
    rst_n   = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    nout    = 224;
    m_ready = 1'b1;
    send(32, 3'd0);
    wait_out(256, 200);
    repeat (40) @(posedge clk);
    #1;
    chk("midrst_no_stale_frames", 64'(nout), 64'd256);

    foreach (vecs[k]) begin
      chk($sformatf("vec_f%0d_p%0d", vecs[k].frame, vecs[k].pos),
          64'({fmode[vecs[k].frame][vecs[k].pos], frames[vecs[k].frame][vecs[k].pos]}),
          64'({vecs[k].mode, 16'(16'h100 + vecs[k].re), vecs[k].re}));
    end

    for (int f = 0; f < 8; f++) begin
      int cnt;
      int lp;
      cnt = 0;
      lp  = -1;
      for (int p = 0; p < 32; p++) begin
        if (flast[f][p]) begin
          cnt++;
          lp = p;
        end
      end
      chk($sformatf("m_last_f%0d", f), {32'(cnt), 32'(lp)}, {32'd1, 32'd31});
    end

`ifdef FFT_PERM_STREAM_FRAME_CHECK_EN
    reset_pulse(2);
    @(negedge clk);
    chk("ferr_after_reset", 64'(frame_err), 64'd0);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      accept_one(i, 3'd0, i == 30);
      if (i == 29) chk("ferr_clean_before", 64'(frame_err), 64'd0);
      if (i == 30) chk("ferr_set", 64'(frame_err), 64'd1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("ferr_sticky", 64'(frame_err), 64'd1);
    reset_pulse(2);
    @(negedge clk);
    chk("ferr_cleared_by_reset", 64'(frame_err), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_perm_stream.md
Name: fft_perm_stream

Overview:
- Streaming, parametrised successor of the fixed 32-point combinational FFT mapping network.
- Accepts one complex sample per cycle in natural order over a valid/ready stream.
- Buffers each N-sample frame in a ping-pong register bank, then emits it in a per-frame selectable permuted order.
- Sits between FFT butterfly stages, and at the FFT input and output, in place of wide parallel buses.

Parameters:
- N, 32, points per frame; power of two, 4..256.
- DW, 16, bits per real and per imaginary component.
- LOG2N, $clog2(N), index width (derived, not overridable).
- MW, 3, mode field width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input can accept.
- s_data  in  2*DW  {imag, real} sample, natural order.
- s_mode  in  MW  permutation mode; sampled with the first sample of a frame.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream can accept.
- m_data  out  2*DW  permuted sample.
- m_last  out  1  high on the final sample of a frame.
- m_mode  out  MW  mode the current output frame was permuted with.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - wcnt, rcnt, wb, rb cleared to 0; full[1:0] cleared to 0.
  - m_valid, m_last, m_data, m_mode all 0.
  - s_ready is 0 while rst_n is low.
  - Bank contents are not reset.
- Reset mid-frame discards all partial and buffered frames.
- Write side:
  - s_ready = rst_n & !full[wb].
  - Accept occurs when s_valid & s_ready; the sample is written to bank[wb][wcnt] and wcnt increments.
  - An accept with wcnt==0 latches s_mode into mode_q[wb].
  - An accept with wcnt==N-1 sets full[wb]=1, toggles wb and wraps wcnt to 0.
- Read side:
  - The registered output stage loads when full[rb] & (!m_valid | m_ready).
  - Loaded values: m_data = bank[rb][perm(rcnt, mode_q[rb])], m_mode = mode_q[rb], m_last = (rcnt==N-1). rcnt then increments.
  - A load with rcnt==N-1 clears full[rb], toggles rb and wraps rcnt.
  - If there is no load and m_ready=1, m_valid drops to 0.
  - Held output (m_valid & !m_ready) keeps m_data, m_last and m_mode stable.
- perm(i, mode), index function:
  - mode 0: bit-reverse of i over LOG2N bits.
  - mode k, 1 ≤ k ≤ LOG2N-1: i with bit 0 and bit k swapped (per-stage butterfly pairing).
  - mode ≥ LOG2N: identity.
- Latency and throughput:
  - First output m_valid is asserted 2 cycles after the last input of a frame is accepted.
  - Steady state is 1 sample/cycle per frame, with at most 2 bubble cycles between frames.
- Simultaneous events:
  - Write-complete and read-complete in the same cycle on different banks are legal.
  - A bank freed in cycle t is writable from cycle t+1; there is no bypass.
- Both banks full: s_ready=0 until the reader frees one.
- Data is moved bit-exact; there is no arithmetic or rounding.

Optional Feature:
- Macro: FFT_PERM_STREAM_FRAME_CHECK_EN.
- When defined:
  - Adds input s_last (1) and output frame_err (1, sticky, reset 0).
  - frame_err is set on any accept where s_last != (wcnt==N-1).
  - Framing is still driven by wcnt; s_last is advisory only.
  - frame_err clears only on reset.
- When undefined: neither port exists and framing is driven purely by the counter.

Decomposition:
- Package fft_pkg:
  - Mode enum constants MODE_BITREV=0 and MODE_IDENT.
  - Complex sample typedef (2*DW).
  - Function perm_idx(i, mode, LOG2N).
- Sub-module fft_perm_bank: one N-entry register bank with write port and combinational read port, instantiated twice.

Test Plan (N=32, DW=16; input sample i has real=i, imag=0x100+i):
- Mode 0, one frame, m_ready=1 → outputs real 0,16,8,24,4,…,31; m_last on the 32nd output; first m_valid 2 cycles after the 32nd accept.
- Mode 1 frame followed back-to-back by a mode 2 frame → first frame outputs 0,2,1,3,4,6,5,7,…; second frame outputs 0,4,2,6,1,5,3,7,8,…; m_mode is 1 then 2; at most 2 bubble cycles between frames.
- Mode 7 (identity), m_ready toggled 1010… → outputs 0..31 in order; m_data stable while held.
- m_ready=0 while 3 frames are offered → s_ready drops after 64 accepts; releasing m_ready drains frame 0 and then frame 1 intact, and the third frame is accepted only once a bank frees.
- rst_n pulsed low after 10 accepts and 5 outputs → m_valid=0 and s_ready=0 during reset; the next frame outputs a correct mode-0 order with no stale samples.
- With FFT_PERM_STREAM_FRAME_CHECK_EN: s_last asserted on sample 30 → frame_err=1 the next cycle and it stays 1 until reset.
